// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage feeding a DEPTH-entry decoded-instruction FIFO.
// Optional macro DECODE_BYPASS_EN: words arriving at an empty queue skip the FIFO.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int OPW   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            flush,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_ins,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [OPW-1:0]  dec_opcode,
    output logic [6:0]      dec_ophead,
    output logic [XLEN-1:0] dec_imm,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [4:0]      dec_rd,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_illegal
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
    localparam logic [OPW-1:0] OP_AUIPC = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_JALR  = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(7);
    localparam logic [OPW-1:0] OP_BGE   = OPW'(8);
    localparam logic [OPW-1:0] OP_BLTU  = OPW'(9);
    localparam logic [OPW-1:0] OP_BGEU  = OPW'(10);
    localparam logic [OPW-1:0] OP_LB    = OPW'(11);
    localparam logic [OPW-1:0] OP_LH    = OPW'(12);
    localparam logic [OPW-1:0] OP_LW    = OPW'(13);
    localparam logic [OPW-1:0] OP_LBU   = OPW'(14);
    localparam logic [OPW-1:0] OP_LHU   = OPW'(15);
    localparam logic [OPW-1:0] OP_SB    = OPW'(16);
    localparam logic [OPW-1:0] OP_SH    = OPW'(17);
    localparam logic [OPW-1:0] OP_SW    = OPW'(18);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(19);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(20);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(21);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(22);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(23);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(24);
    localparam logic [OPW-1:0] OP_SLLI  = OPW'(25);
    localparam logic [OPW-1:0] OP_SRLI  = OPW'(26);
    localparam logic [OPW-1:0] OP_SRAI  = OPW'(27);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(28);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(29);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(30);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(31);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(32);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(33);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(34);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(35);
    localparam logic [OPW-1:0] OP_OR    = OPW'(36);
    localparam logic [OPW-1:0] OP_AND   = OPW'(37);

    typedef struct packed {
        logic [OPW-1:0]  opcode;
        logic [6:0]      ophead;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [XLEN-1:0] ins,
                                      input logic [XLEN-1:0] pc);
        entry_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic use_rs1, use_rs2, use_rd;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.ophead = ins[6:0];
        e.pc = pc;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                e.opcode = (ins[5]) ? OP_LUI : OP_AUIPC;
                e.imm = XLEN'($signed({ins[31:12], 12'b0}));
                use_rd = 1'b1;
            end
            7'h6f: begin
                e.opcode = OP_JAL;
                e.imm = XLEN'($signed({ins[31], ins[19:12], ins[20],
                                       ins[30:21], 1'b0}));
                use_rd = 1'b1;
            end
            7'h67: begin
                e.opcode = (f3 == 3'd0) ? OP_JALR : '0;
                e.imm = XLEN'($signed(ins[31:20]));
                use_rs1 = 1'b1;
                use_rd = 1'b1;
            end
            7'h63: begin
                case (f3)
                    3'd0: e.opcode = OP_BEQ;
                    3'd1: e.opcode = OP_BNE;
                    3'd4: e.opcode = OP_BLT;
                    3'd5: e.opcode = OP_BGE;
                    3'd6: e.opcode = OP_BLTU;
                    3'd7: e.opcode = OP_BGEU;
                    default: e.opcode = '0;
                endcase
                e.imm = XLEN'($signed({ins[31], ins[7], ins[30:25],
                                       ins[11:8], 1'b0}));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'h03: begin
                case (f3)
                    3'd0: e.opcode = OP_LB;
                    3'd1: e.opcode = OP_LH;
                    3'd2: e.opcode = OP_LW;
                    3'd4: e.opcode = OP_LBU;
                    3'd5: e.opcode = OP_LHU;
                    default: e.opcode = '0;
                endcase
                e.imm = XLEN'($signed(ins[31:20]));
                use_rs1 = 1'b1;
                use_rd = 1'b1;
            end
            7'h23: begin
                case (f3)
                    3'd0: e.opcode = OP_SB;
                    3'd1: e.opcode = OP_SH;
                    3'd2: e.opcode = OP_SW;
                    default: e.opcode = '0;
                endcase
                e.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'h13: begin
                e.imm = XLEN'($signed(ins[31:20]));
                case (f3)
                    3'd0: e.opcode = OP_ADDI;
                    3'd2: e.opcode = OP_SLTI;
                    3'd3: e.opcode = OP_SLTIU;
                    3'd4: e.opcode = OP_XORI;
                    3'd6: e.opcode = OP_ORI;
                    3'd7: e.opcode = OP_ANDI;
                    3'd1: e.opcode = (f7 == 7'h00) ? OP_SLLI : '0;
                    default: begin
                        if (f7 == 7'h00) e.opcode = OP_SRLI;
                        else if (f7 == 7'h20) e.opcode = OP_SRAI;
                        else e.opcode = '0;
                    end
                endcase
                // shifts carry a 5-bit shamt, never sign-extended
                if (f3 == 3'd1 || f3 == 3'd5) e.imm = XLEN'(ins[24:20]);
                use_rs1 = 1'b1;
                use_rd = 1'b1;
            end
            7'h33: begin
                case ({f7, f3})
                    {7'h00, 3'd0}: e.opcode = OP_ADD;
                    {7'h20, 3'd0}: e.opcode = OP_SUB;
                    {7'h00, 3'd1}: e.opcode = OP_SLL;
                    {7'h00, 3'd2}: e.opcode = OP_SLT;
                    {7'h00, 3'd3}: e.opcode = OP_SLTU;
                    {7'h00, 3'd4}: e.opcode = OP_XOR;
                    {7'h00, 3'd5}: e.opcode = OP_SRL;
                    {7'h20, 3'd5}: e.opcode = OP_SRA;
                    {7'h00, 3'd6}: e.opcode = OP_OR;
                    {7'h00, 3'd7}: e.opcode = OP_AND;
                    default: e.opcode = '0;
                endcase
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd = 1'b1;
            end
            default: e.opcode = '0;
        endcase
        e.illegal = (e.opcode == '0);
        if (e.illegal) e.imm = '0;
        e.rs1 = (use_rs1 && !e.illegal) ? ins[19:15] : 5'd0;
        e.rs2 = (use_rs2 && !e.illegal) ? ins[24:20] : 5'd0;
        e.rd = (use_rd && !e.illegal) ? ins[11:7] : 5'd0;
        return e;
    endfunction

    entry_t         mem [DEPTH];
    entry_t         in_e;
    entry_t         out_e;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           bypass;

    assign in_e = decode(if_ins, if_pc);
    assign full = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

`ifdef DECODE_BYPASS_EN
    assign bypass = empty & if_valid & dec_ready & rdy & !flush & rst_n;
`else
    assign bypass = 1'b0;
`endif

    assign if_ready = rst_n & rdy & !full;
    assign dec_valid = (rdy & !empty) | bypass;
    assign push = if_valid & if_ready & !bypass;
    assign pop = rdy & !empty & dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop) head <= head + AW'(1);
                case ({push, pop})
                    2'b10: count <= count + (AW+1)'(1);
                    2'b01: count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= in_e;
    end

    always_comb begin
        out_e = '0;
        if (bypass) out_e = in_e;
        else if (!empty) out_e = mem[head];
    end

    assign dec_opcode = out_e.opcode;
    assign dec_ophead = out_e.ophead;
    assign dec_imm = out_e.imm;
    assign dec_rs1 = out_e.rs1;
    assign dec_rs2 = out_e.rs2;
    assign dec_rd = out_e.rd;
    assign dec_pc = out_e.pc;
    assign dec_illegal = out_e.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed and random checks of decode_queue against a
// rule-table decoder and a word queue.
module tb_decode_queue;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int OPW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rdy;
    logic            flush;
    logic            if_valid;
    logic [XLEN-1:0] if_ins;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            dec_valid;
    logic            dec_ready;
    logic [OPW-1:0]  dec_opcode;
    logic [6:0]      dec_ophead;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_pc;
    logic            dec_illegal;

    always #5 clk = ~clk;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
        .if_ready(if_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_ophead(dec_ophead), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_pc(dec_pc), .dec_illegal(dec_illegal)
    );

    typedef struct {
        logic [6:0] op;
        int         f3;
        int         f7;
        int         id;
        byte        fmt;
    } rule_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } word_t;

    typedef struct {
        logic [31:0] opc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rd;
        logic [31:0] ill;
    } exp_t;

    rule_t       tbl[$];
    word_t       q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pc_ctr = 0;

    task automatic add(logic [6:0] op, int f3, int f7, int id, byte fmt);
        rule_t r;
        r = '{op: op, f3: f3, f7: f7, id: id, fmt: fmt};
        tbl.push_back(r);
    endtask

    // first matching rule wins; no match means illegal
    function automatic exp_t ref_dec(logic [31:0] w);
        exp_t e;
        int   s;
        bit   hit;
        e = '{opc: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, ill: 1};
        hit = 0;
        foreach (tbl[i]) begin
            if (hit) continue;
            if (w[6:0] != tbl[i].op) continue;
            if (tbl[i].f3 >= 0 && int'(w[14:12]) != tbl[i].f3) continue;
            if (tbl[i].f7 >= 0 && int'(w[31:25]) != tbl[i].f7) continue;
            hit = 1;
            e.ill = 0;
            e.opc = tbl[i].id;
            case (tbl[i].fmt)
                "U": begin
                    e.imm = w & 32'hFFFF_F000;
                    e.rd = w[11:7];
                end
                "J": begin
                    s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
                    e.imm = s;
                    e.rd = w[11:7];
                end
                "I": begin
                    s = $signed(w[31:20]);
                    e.imm = s;
                    e.rs1 = w[19:15];
                    e.rd = w[11:7];
                end
                "H": begin
                    e.imm = w[24:20];
                    e.rs1 = w[19:15];
                    e.rd = w[11:7];
                end
                "S": begin
                    s = $signed({w[31:25], w[11:7]});
                    e.imm = s;
                    e.rs1 = w[19:15];
                    e.rs2 = w[24:20];
                end
                "B": begin
                    s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
                    e.imm = s;
                    e.rs1 = w[19:15];
                    e.rs2 = w[24:20];
                end
                default: begin
                    e.rs1 = w[19:15];
                    e.rs2 = w[24:20];
                    e.rd = w[11:7];
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [31:0] w;
        rule_t r;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            r = tbl[$urandom_range(0, tbl.size() - 1)];
            w[6:0] = r.op;
            if (r.f3 >= 0) w[14:12] = r.f3[2:0];
            if (r.f7 >= 0) w[31:25] = r.f7[6:0];
        end
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(bit r);
        exp_t  e;
        word_t h;
        bit    ne;
        ne = (q.size() > 0);
        chk("if_ready", 32'(if_ready), 32'(r && q.size() < DEPTH));
        chk("dec_valid", 32'(dec_valid), 32'(r && ne));
        if (ne) begin
            h = q[0];
            e = ref_dec(h.ins);
        end else begin
            h = '{ins: 0, pc: 0};
            e = '{opc: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, ill: 0};
        end
        chk("opcode", 32'(dec_opcode), e.opc);
        chk("ophead", 32'(dec_ophead), 32'(h.ins[6:0]));
        chk("imm", dec_imm, e.imm);
        chk("rs1", 32'(dec_rs1), e.rs1);
        chk("rs2", 32'(dec_rs2), e.rs2);
        chk("rd", 32'(dec_rd), e.rd);
        chk("pc", dec_pc, h.pc);
        chk("illegal", 32'(dec_illegal), e.ill);
    endtask

    task automatic step(bit r, bit f, bit v, logic [31:0] ins, bit d);
        bit ifr;
        bit dv;
        rdy = r;
        flush = f;
        if_valid = v;
        if_ins = ins;
        if_pc = pc_ctr;
        dec_ready = d;
        #1;
        check_outputs(r);
        ifr = r && (q.size() < DEPTH);
        dv = r && (q.size() > 0);
        @(posedge clk);
        if (r) begin
            if (f) begin
                q.delete();
            end else begin
                if (dv && d) void'(q.pop_front());
                if (v && ifr) q.push_back('{ins: ins, pc: pc_ctr});
            end
        end
        pc_ctr += 4;
        #1;
    endtask

    initial begin
        logic [31:0] saved_pc;
        int guard;

        add(7'h37, -1, -1, 1, "U");
        add(7'h17, -1, -1, 2, "U");
        add(7'h6f, -1, -1, 3, "J");
        add(7'h67, 0, -1, 4, "I");
        add(7'h63, 0, -1, 5, "B");
        add(7'h63, 1, -1, 6, "B");
        add(7'h63, 4, -1, 7, "B");
        add(7'h63, 5, -1, 8, "B");
        add(7'h63, 6, -1, 9, "B");
        add(7'h63, 7, -1, 10, "B");
        add(7'h03, 0, -1, 11, "I");
        add(7'h03, 1, -1, 12, "I");
        add(7'h03, 2, -1, 13, "I");
        add(7'h03, 4, -1, 14, "I");
        add(7'h03, 5, -1, 15, "I");
        add(7'h23, 0, -1, 16, "S");
        add(7'h23, 1, -1, 17, "S");
        add(7'h23, 2, -1, 18, "S");
        add(7'h13, 0, -1, 19, "I");
        add(7'h13, 2, -1, 20, "I");
        add(7'h13, 3, -1, 21, "I");
        add(7'h13, 4, -1, 22, "I");
        add(7'h13, 6, -1, 23, "I");
        add(7'h13, 7, -1, 24, "I");
        add(7'h13, 1, 'h00, 25, "H");
        add(7'h13, 5, 'h00, 26, "H");
        add(7'h13, 5, 'h20, 27, "H");
        add(7'h33, 0, 'h00, 28, "R");
        add(7'h33, 0, 'h20, 29, "R");
        add(7'h33, 1, 'h00, 30, "R");
        add(7'h33, 2, 'h00, 31, "R");
        add(7'h33, 3, 'h00, 32, "R");
        add(7'h33, 4, 'h00, 33, "R");
        add(7'h33, 5, 'h00, 34, "R");
        add(7'h33, 5, 'h20, 35, "R");
        add(7'h33, 6, 'h00, 36, "R");
        add(7'h33, 7, 'h00, 37, "R");

        rst_n = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        if_valid = 1'b1;
        if_ins = 32'hFFF0_0093;
        if_pc = 32'h0;
        dec_ready = 1'b1;
        #2;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_imm", dec_imm, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        #1;
        rst_n = 1'b1;

        // single ADDI, visible one cycle later
        step(1, 0, 1, 32'hFFF0_0093, 0);
        chk("addi_valid", 32'(dec_valid), 32'd1);
        chk("addi_opcode", 32'(dec_opcode), 32'd19);
        chk("addi_rd", 32'(dec_rd), 32'd1);
        chk("addi_rs1", 32'(dec_rs1), 32'd0);
        chk("addi_rs2", 32'(dec_rs2), 32'd0);
        chk("addi_imm", dec_imm, 32'hFFFF_FFFF);
        chk("addi_pc", dec_pc, 32'h0);
        step(1, 0, 0, 32'h0, 1);

        // back-to-back SW, JAL, LUI with dispatch always ready
        step(1, 0, 1, 32'h0020_A423, 1);
        chk("sw_opcode", 32'(dec_opcode), 32'd18);
        chk("sw_rs1", 32'(dec_rs1), 32'd1);
        chk("sw_rs2", 32'(dec_rs2), 32'd2);
        chk("sw_rd", 32'(dec_rd), 32'd0);
        chk("sw_imm", dec_imm, 32'd8);
        step(1, 0, 1, 32'h0100_00EF, 1);
        chk("jal_opcode", 32'(dec_opcode), 32'd3);
        chk("jal_rd", 32'(dec_rd), 32'd1);
        chk("jal_imm", dec_imm, 32'd16);
        step(1, 0, 1, 32'h1234_52B7, 1);
        chk("lui_opcode", 32'(dec_opcode), 32'd1);
        chk("lui_rd", 32'(dec_rd), 32'd5);
        chk("lui_imm", dec_imm, 32'h1234_5000);
        step(1, 0, 0, 32'h0, 1);

        // fill, refuse push on full even with a pop, then wrap
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, rnd_ins(), 0);
        chk("full_if_ready", 32'(if_ready), 32'd0);
        step(1, 0, 1, rnd_ins(), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 1);
        chk("count3_empty", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, rnd_ins(), $urandom_range(0, 1));
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            step(1, 0, 0, 32'h0, 1);
            guard++;
        end
        chk("drain_empty", 32'(dec_valid), 32'd0);

        // flush with a concurrent push
        for (int i = 0; i < 3; i++) step(1, 0, 1, rnd_ins(), 0);
        step(1, 1, 1, 32'h0000_0013, 1);
        chk("flush_valid", 32'(dec_valid), 32'd0);
        chk("flush_if_ready", 32'(if_ready), 32'd1);

        // unsupported major opcode
        step(1, 0, 1, 32'h0000_007F, 0);
        chk("ill_flag", 32'(dec_illegal), 32'd1);
        chk("ill_opcode", 32'(dec_opcode), 32'd0);
        chk("ill_rs1", 32'(dec_rs1), 32'd0);
        chk("ill_rs2", 32'(dec_rs2), 32'd0);
        chk("ill_rd", 32'(dec_rd), 32'd0);
        step(1, 0, 0, 32'h0, 1);

        // freeze with rdy low, then async reset mid-stream
        step(1, 0, 1, rnd_ins(), 0);
        step(1, 0, 1, rnd_ins(), 0);
        saved_pc = q[0].pc;
        for (int i = 0; i < 3; i++) step(0, 1, 1, rnd_ins(), 1);
        step(1, 0, 0, 32'h0, 0);
        chk("resume_pc", dec_pc, saved_pc);
        chk("resume_valid", 32'(dec_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dec_valid), 32'd0);
        chk("async_rst_if_ready", 32'(if_ready), 32'd0);
        chk("async_rst_pc", dec_pc, 32'd0);
        q.delete();
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, rnd_ins(),
                 $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered RISC-V RV32I decode stage between instruction fetch and dispatch (ROB/RS/LSB).
- Each fetched word is decoded on enqueue: internal opcode, register fields and generated immediate.
- Decoded entries are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Supports flush on branch mispredict.

Parameters:
- XLEN, 32, instruction/PC/immediate width.
- DEPTH, 4, queue entries; power of two, >= 2.
- OPW, 6, internal opcode width; encoding per defines.v macros.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  discard all queued entries (mispredict)
- if_valid  in  1  fetch word present
- if_ins  in  XLEN  instruction word
- if_pc  in  XLEN  instruction PC
- if_ready  out  1  queue accepts a word this cycle
- dec_valid  out  1  head entry valid
- dec_ready  in  1  dispatch consumes head
- dec_opcode  out  OPW  internal opcode (`ADDI, `SW, ...)
- dec_ophead  out  7  ins[6:0]
- dec_imm  out  XLEN  generated immediate
- dec_rs1, dec_rs2, dec_rd  out  5 each  register fields
- dec_pc  out  XLEN  PC of head entry
- dec_illegal  out  1  head entry is not a supported RV32I encoding

Behaviour:
- Reset (async, rst_n=0): head/tail pointers and count are cleared to 0. While rst_n=0, dec_valid=0, if_ready=0, and all dec_* payload outputs are 0.
- Handshakes:
  - if_ready = rst_n & rdy & !full.
  - dec_valid = rdy & !empty.
  - Push when if_valid & if_ready; pop when dec_valid & dec_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: if_ready=0 even if a pop occurs in the same cycle (no pass-through on full).
- Pointers wrap modulo DEPTH.
- Latency: a pushed word appears at the head no earlier than the next cycle (1-cycle minimum).
- Payload: dec_* outputs are driven from the head entry and are 0 when empty.
- flush: highest priority. At the next edge, pointers and count are cleared. Any push or pop in that cycle is discarded.
- rdy=0: no state change; flush is ignored. if_ready=0 and dec_valid=0.
- Decode is performed on the pushed word:
  - Opcode per the RV32I table: B, load, store, OP-IMM, OP, LUI, AUIPC, JAL, JALR.
  - Unknown major opcode, funct3, or funct7 gives dec_opcode=0 and dec_illegal=1.
- Immediate generation (sign-extended to XLEN):
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U: {ins[31:12], 12'b0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - SLLI/SRLI/SRAI: ins[24:20] zero-extended.
  - R-type: 0.
- Register fields:
  - rd forced 0 for B and S.
  - rs2 forced 0 for I, U and J.
  - rs1 forced 0 for U and J.
  - Illegal entries: all register fields 0.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when the queue is empty, and if_valid & dec_ready & rdy & !flush, the word is decoded and presented combinationally on dec_* in the same cycle with dec_valid=1. It is consumed without being written to the queue (0-cycle latency).
- Undefined: minimum latency is 1 cycle, as above.

Test Plan:
- Reset then push 0xFFF00093 at pc 0x0 -> next cycle dec_valid=1, dec_opcode=`ADDI, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF, pc=0x0.
- Push 0x0020A423, 0x010000EF, 0x123452B7 back-to-back with dec_ready=1 -> heads in order:
  - 0x0020A423: `SW, rs1=1, rs2=2, rd=0, imm=8.
  - 0x010000EF: `JAL, rd=1, imm=16.
  - 0x123452B7: `LUI, rd=5, imm=0x12345000.
- dec_ready=0, push DEPTH words -> if_ready=0 after the 4th push. Pop one with a simultaneous push -> push refused, count=3. Then wrap-around order preserved across 8 further words.
- Queue holding 3 entries, assert flush with if_valid=1 -> next cycle dec_valid=0, count=0, pushed word absent.
- Push 0x0000007F -> dec_illegal=1, dec_opcode=0, all register fields 0.
- rdy=0 for 3 cycles mid-stream with if_valid/dec_ready high -> no push/pop, outputs resume with identical head afterwards. Assert rst_n=0 mid-stream -> dec_valid drops immediately (asynchronously).
